control_unit: RTL
=================

Name: control_unit

Overview:
- Sequencer and decoder that drives the 5-bit accumulator datapath: the ALU function select, the data-bus driver enable, the result driver enable and the accumulator load.
- Fetches 9-bit instructions from an external synchronous program ROM (1-cycle read latency).
- Latches the datapath's C/ZE flags and resolves conditional jumps. This is the initiating end of the datapath control interface.

Parameters:
- PC_W, 5, program counter width (must be >= 5); ROM depth is 2^PC_W.
- INSTR_W, 9, instruction width; opcode = instr[8:5], operand = instr[4:0]. Fixed at 9.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  permits leaving FETCH; low holds the FSM in FETCH
- instr_in  in  9  ROM read data, valid the cycle after pc_out is presented
- c_in  in  1  ALU carry flag from datapath
- ze_in  in  1  ALU zero flag from datapath
- pc_out  out  PC_W  ROM address
- operand  out  5  IR[4:0], the immediate driven onto the data bus
- f_sel  out  3  ALU function select
- en_db  out  1  data-bus tristate enable
- en_r  out  1  result tristate enable
- en_acc  out  1  accumulator load strobe
- c_flag  out  1  latched carry
- z_flag  out  1  latched zero
- halt  out  1  high while halted

Behaviour:
- FSM states: FETCH -> DECODE -> EXECUTE -> FETCH, plus HALT. Three cycles per instruction.
- FETCH: pc_out is presented to the ROM. The FSM advances to DECODE only when run=1; otherwise it stays in FETCH with PC unchanged.
- DECODE: IR <= instr_in; PC <= PC+1 modulo 2^PC_W (wrap from all-ones to 0).
- EXECUTE: control outputs are decoded from IR for exactly one cycle. In every other state f_sel=000 and en_db=en_r=en_acc=0.
- Opcodes (all others behave as NOP):
  - 0 NOP: no enables.
  - 1 LDI: f_sel=010, en_db=1, en_acc=1.
  - 2 ADDI: f_sel=011, en_db=1, en_acc=1.
  - 3 SUBI: f_sel=001, en_db=1, en_acc=1.
  - 4 NANDI: f_sel=100, en_db=1, en_acc=1.
  - 5 OUT: f_sel=000, en_r=1.
  - 6 JMP: PC <= operand, zero-extended to PC_W.
  - 7 JC: jump if c_flag=1.
  - 8 JZ: jump if z_flag=1.
  - 9 JNC: jump if c_flag=0.
  - A JNZ: jump if z_flag=0.
  - F HLT: enter HALT.
- Jumps: the target load at the end of EXECUTE overrides the increment already done in DECODE. Conditions use the flag values latched before this instruction.
- Flags: at the clk edge ending EXECUTE of opcodes 1-4, c_flag <= c_in and z_flag <= ze_in. No other opcode changes the flags.
- HALT: halt=1, all enables 0, PC and flags frozen. Only reset exits. The run input is ignored.
- Reset, asynchronous at any time including mid-instruction:
  - state=FETCH, PC=0, IR=0, flags=0, halt=0.
  - f_sel=000, en_db=en_r=en_acc=0.
  - No partial en_acc pulse may survive reset assertion.
- run falling during DECODE or EXECUTE does not stall; the current instruction completes and the FSM then holds in FETCH.
- Simultaneous JC with a flag update: impossible by construction, because jumps never update flags.

Decomposition:
- Package control_pkg holds:
  - opcode localparams OP_NOP..OP_HLT;
  - ALU function codes F_PASSA=000, F_SUB=001, F_PASSB=010, F_ADD=011, F_NAND=100;
  - state encoding S_FETCH, S_DECODE, S_EXEC, S_HALT.
- One sub-module, control_decoder: purely combinational. Maps opcode to f_sel, en_db, en_r, en_acc, is_alu, is_jump and jump condition. The top level holds the FSM, PC, IR and flags, and gates the decoder outputs with state==S_EXEC.

Test Plan:
- Reset, then run=1 with ROM[0]=LDI 5 -> in the cycle-3 EXECUTE: f_sel=010, en_db=1, en_acc=1, operand=00101. In the following FETCH, pc_out=1 and all enables are 0.
- Carry flag and JC taken: ROM: LDI 31, ADDI 1, JC 7; bench drives c_in=1, ze_in=1 during the ADDI EXECUTE -> c_flag=1, z_flag=1 afterwards; pc_out=7 in the FETCH after JC.
- JNZ not taken: z_flag=1, ROM[2]=JNZ 0 -> next pc_out=3 and the flags are unchanged.
- run=0 held for 10 cycles in FETCH -> pc_out constant and no enables. After run=1, the instruction completes in 3 cycles.
- PC_W=5: execute NOP at address 31 -> next pc_out=0 (wrap).
- HLT at address 4 -> halt=1 forever, pc_out=5 frozen, enables 0. Then async reset asserted mid-cycle -> immediately halt=0, pc_out=0, flags 0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the accumulator-datapath control unit: opcodes,
// ALU function codes, FSM state encoding and jump-condition helper.
package control_pkg;

  // Opcodes, instr[8:5]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_SUBI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JC    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNC   = 4'h9;
  localparam logic [3:0] OP_JNZ   = 4'hA;
  localparam logic [3:0] OP_HLT   = 4'hF;

  // ALU function select codes
  localparam logic [2:0] F_PASSA = 3'b000;
  localparam logic [2:0] F_SUB   = 3'b001;
  localparam logic [2:0] F_PASSB = 3'b010;
  localparam logic [2:0] F_ADD   = 3'b011;
  localparam logic [2:0] F_NAND  = 3'b100;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    JC_ALWAYS = 3'd0,
    JC_C      = 3'd1,
    JC_Z      = 3'd2,
    JC_NC     = 3'd3,
    JC_NZ     = 3'd4
  } jcond_t;

  // Resolve a jump condition against the latched flags
  function automatic logic jump_taken(input jcond_t cond, input logic c, input logic z);
    logic taken;
    case (cond)
      JC_ALWAYS: taken = 1'b1;
      JC_C:      taken = c;
      JC_Z:      taken = z;
      JC_NC:     taken = ~c;
      JC_NZ:     taken = ~z;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode decoder: datapath enables, ALU select and
// instruction class (ALU / jump / halt) with the jump condition.
module control_decoder
  import control_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] f_sel,
  output logic       en_db,
  output logic       en_r,
  output logic       en_acc,
  output logic       is_alu,
  output logic       is_jump,
  output logic       is_halt,
  output jcond_t     jcond
);

  // Opcode to control-word lookup; unknown opcodes decode as NOP
  always_comb begin
    f_sel   = F_PASSA;
    en_db   = 1'b0;
    en_r    = 1'b0;
    en_acc  = 1'b0;
    is_alu  = 1'b0;
    is_jump = 1'b0;
    is_halt = 1'b0;
    jcond   = JC_ALWAYS;
    case (opcode)
      OP_LDI:   begin f_sel = F_PASSB; en_db = 1'b1; en_acc = 1'b1; is_alu = 1'b1; end
      OP_ADDI:  begin f_sel = F_ADD;   en_db = 1'b1; en_acc = 1'b1; is_alu = 1'b1; end
      OP_SUBI:  begin f_sel = F_SUB;   en_db = 1'b1; en_acc = 1'b1; is_alu = 1'b1; end
      OP_NANDI: begin f_sel = F_NAND;  en_db = 1'b1; en_acc = 1'b1; is_alu = 1'b1; end
      OP_OUT:   begin en_r = 1'b1; end
      OP_JMP:   begin is_jump = 1'b1; jcond = JC_ALWAYS; end
      OP_JC:    begin is_jump = 1'b1; jcond = JC_C; end
      OP_JZ:    begin is_jump = 1'b1; jcond = JC_Z; end
      OP_JNC:   begin is_jump = 1'b1; jcond = JC_NC; end
      OP_JNZ:   begin is_jump = 1'b1; jcond = JC_NZ; end
      OP_HLT:   begin is_halt = 1'b1; end
      default:  begin f_sel = F_PASSA; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 5-bit accumulator datapath.
// Control outputs are registered: they are computed in DECODE from the
// incoming ROM word and are therefore valid for exactly the EXECUTE cycle.
module control_unit
  import control_pkg::*;
#(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               c_in,
  input  logic               ze_in,
  output logic [PC_W-1:0]    pc_out,
  output logic [4:0]         operand,
  output logic [2:0]         f_sel,
  output logic               en_db,
  output logic               en_r,
  output logic               en_acc,
  output logic               c_flag,
  output logic               z_flag,
  output logic               halt
);

  state_t            state_r, next_state_s;
  logic [PC_W-1:0]   pc_r, jump_target_s;
  logic [INSTR_W-1:0] ir_r;
  logic              c_flag_r, z_flag_r, halt_r;
  logic [2:0]        f_sel_r, f_sel_nxt_s;
  logic              en_db_r, en_r_r, en_acc_r;
  logic              en_db_nxt_s, en_r_nxt_s, en_acc_nxt_s, halt_nxt_s;
  logic [3:0]        dec_op_s;
  logic [2:0]        dec_f_sel_s;
  logic              dec_en_db_s, dec_en_r_s, dec_en_acc_s;
  logic              dec_is_alu_s, dec_is_jump_s, dec_is_halt_s;
  jcond_t            dec_jcond_s;
  logic              take_jump_s, flag_upd_s;

  // Decoder sees the incoming word in DECODE and the held IR in EXECUTE
  always_comb begin
    if (state_r == S_DECODE) dec_op_s = instr_in[8:5];
    else                     dec_op_s = ir_r[8:5];
  end

  control_decoder u_decoder (
    .opcode  (dec_op_s),
    .f_sel   (dec_f_sel_s),
    .en_db   (dec_en_db_s),
    .en_r    (dec_en_r_s),
    .en_acc  (dec_en_acc_s),
    .is_alu  (dec_is_alu_s),
    .is_jump (dec_is_jump_s),
    .is_halt (dec_is_halt_s),
    .jcond   (dec_jcond_s)
  );

  // Jump resolution and flag-update qualification for the EXECUTE cycle
  always_comb begin
    jump_target_s      = '0;
    jump_target_s[4:0] = ir_r[4:0];
    take_jump_s = (state_r == S_EXEC) && dec_is_jump_s &&
                  jump_taken(dec_jcond_s, c_flag_r, z_flag_r);
    flag_upd_s  = (state_r == S_EXEC) && dec_is_alu_s;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= next_state_s;
  end

  // FSM next-state logic; HALT is left only through reset
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH:  next_state_s = run ? S_DECODE : S_FETCH;
      S_DECODE: next_state_s = S_EXEC;
      S_EXEC:   next_state_s = dec_is_halt_s ? S_HALT : S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // FSM output logic: next-cycle control word, non-zero only entering EXECUTE
  always_comb begin
    f_sel_nxt_s  = F_PASSA;
    en_db_nxt_s  = 1'b0;
    en_r_nxt_s   = 1'b0;
    en_acc_nxt_s = 1'b0;
    if (state_r == S_DECODE) begin
      f_sel_nxt_s  = dec_f_sel_s;
      en_db_nxt_s  = dec_en_db_s;
      en_r_nxt_s   = dec_en_r_s;
      en_acc_nxt_s = dec_en_acc_s;
    end else begin
      f_sel_nxt_s  = F_PASSA;
      en_db_nxt_s  = 1'b0;
      en_r_nxt_s   = 1'b0;
      en_acc_nxt_s = 1'b0;
    end
    halt_nxt_s = (next_state_s == S_HALT);
  end

  // Output registers; async reset kills any in-flight enable pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_sel_r  <= F_PASSA;
      en_db_r  <= 1'b0;
      en_r_r   <= 1'b0;
      en_acc_r <= 1'b0;
      halt_r   <= 1'b0;
    end else begin
      f_sel_r  <= f_sel_nxt_s;
      en_db_r  <= en_db_nxt_s;
      en_r_r   <= en_r_nxt_s;
      en_acc_r <= en_acc_nxt_s;
      halt_r   <= halt_nxt_s;
    end
  end

  // PC, IR and flags; a taken jump overrides the DECODE increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r     <= '0;
      ir_r     <= '0;
      c_flag_r <= 1'b0;
      z_flag_r <= 1'b0;
    end else begin
      if (state_r == S_DECODE) begin
        ir_r <= instr_in;
        pc_r <= pc_r + PC_W'(1);
      end else if (take_jump_s) begin
        pc_r <= jump_target_s;
      end else begin
        pc_r <= pc_r;
      end
      if (flag_upd_s) begin
        c_flag_r <= c_in;
        z_flag_r <= ze_in;
      end else begin
        c_flag_r <= c_flag_r;
        z_flag_r <= z_flag_r;
      end
    end
  end

  assign pc_out  = pc_r;
  assign operand = ir_r[4:0];
  assign f_sel   = f_sel_r;
  assign en_db   = en_db_r;
  assign en_r    = en_r_r;
  assign en_acc  = en_acc_r;
  assign c_flag  = c_flag_r;
  assign z_flag  = z_flag_r;
  assign halt    = halt_r;

endmodule
